// File: rtl/adc_byte_packer.sv
//-----------------------------------------------------------------------------
// adc_byte_packer
//
// Turns the 12-bit ADC sample stream into a byte stream for the USB readback
// path, and buffers those bytes in a small first-word-fall-through FIFO.
//
//   8-bit low-resolution mode : one byte per sample (sample[11:4])
//   12-bit packed mode        : three bytes per sample pair
//                               s0[11:4], {s0[3:0], s1[11:8]}, s1[7:0]
//
// The ADC cannot be stalled. A sample that does not fit is dropped whole, and
// the sticky overflow flag records the loss.
//
// Optional build macro: ADC_BYTE_PACKER_TESTPATTERN_EN
//   When defined, din is ignored. A 12-bit counter that advances on every
//   accepted sample is packed instead, so the host can check readback
//   integrity. In 8-bit mode the counter's low byte is emitted.
//
// Parameters
//   pFIFO_DEPTH   byte FIFO depth (power of 2, >= 4)
//   pCOUNT_WIDTH  width of fifo_count, log2(pFIFO_DEPTH)+1
//
// Ports
//   adc_sampleclk    sample clock; the whole block runs in this domain
//   reset_n          asynchronous active-low reset
//   clear            synchronous clear of FIFO, residue and overflow
//   low_res          1 = 8-bit mode, 0 = 12-bit packed mode
//   din              ADC sample
//   din_valid        sample strobe, at most one sample per clock
//   flush            pulse: pad and emit any held 4-bit residue
//   dout             byte at the FIFO head (registered)
//   dout_valid       dout holds a valid byte
//   dout_ready       consumer takes dout when dout_valid && dout_ready
//   overflow         sticky: at least one sample was dropped
//   fifo_count       bytes held, including the one shown on dout
//   residue_pending  4 bits held waiting for the second sample of a pair
//-----------------------------------------------------------------------------
module adc_byte_packer #(
    parameter int pFIFO_DEPTH  = 16,
    parameter int pCOUNT_WIDTH = 5
) (
    input  logic                    adc_sampleclk,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    low_res,
    input  logic [11:0]             din,
    input  logic                    din_valid,
    input  logic                    flush,
    output logic [7:0]              dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    overflow,
    output logic [pCOUNT_WIDTH-1:0] fifo_count,
    output logic                    residue_pending
);

    localparam int PTR_W = $clog2(pFIFO_DEPTH);

    localparam logic [pCOUNT_WIDTH-1:0] DEPTH_C = pCOUNT_WIDTH'(pFIFO_DEPTH);
    localparam logic [pCOUNT_WIDTH-1:0] ONE_C   = pCOUNT_WIDTH'(1);
    localparam logic [pCOUNT_WIDTH-1:0] TWO_C   = pCOUNT_WIDTH'(2);

    // EVEN: no residue held. ODD: low nibble of the first sample of a pair held.
    typedef enum logic {
        ST_EVEN = 1'b0,
        ST_ODD  = 1'b1
    } packState_t;

    packState_t              state_q, state_d;
    logic [3:0]              residue_q, residue_d;
    logic                    flushPend_q, flushPend_d;
    logic                    overflow_q, overflow_d;

    logic [PTR_W-1:0]        wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]        rdPtr_q, rdPtr_d;
    logic [pCOUNT_WIDTH-1:0] count_q, count_d;
    logic [7:0]              dout_q, dout_d;
    logic                    doutValid_q, doutValid_d;

    logic [7:0]              mem [pFIFO_DEPTH];

    logic [11:0]             sample;
    logic [7:0]              lowResByte;
    logic                    sampleAccepted;

    logic                    wrEn0, wrEn1;
    logic [7:0]              wrByte0, wrByte1;
    logic [PTR_W-1:0]        wrPtrPlus1;

    logic [pCOUNT_WIDTH-1:0] freeSpace;
    logic                    pop;
    logic [PTR_W-1:0]        rdNext;
    logic [pCOUNT_WIDTH-1:0] remaining;

`ifdef ADC_BYTE_PACKER_TESTPATTERN_EN
    logic [11:0]             patCnt_q, patCnt_d;

    // The pattern counter stands in for the ADC. It only advances on samples
    // that were actually stored, so a gap seen by the host means data was lost.
    always_comb begin
        patCnt_d = patCnt_q;
        if (sampleAccepted) begin
            patCnt_d = patCnt_q + 12'd1;
        end
    end

    always_ff @(posedge adc_sampleclk or negedge reset_n) begin
        if (!reset_n) begin
            patCnt_q <= 12'd0;
        end else if (clear) begin
            patCnt_q <= 12'd0;
        end else begin
            patCnt_q <= patCnt_d;
        end
    end

    assign sample     = patCnt_q;
    assign lowResByte = patCnt_q[7:0];
`else
    assign sample     = din;
    assign lowResByte = din[11:4];
`endif

    // Space is judged on the count before this cycle's pop, so a byte leaving
    // the head never makes room for a byte arriving in the same clock.
    assign freeSpace = DEPTH_C - count_q;
    assign pop       = doutValid_q & dout_ready;

    // Packing state machine. It decides which bytes, if any, enter the FIFO
    // this cycle. A sample that does not fit changes nothing except the
    // overflow flag, so packing alignment survives a drop. Seeing low_res
    // while a residue is held throws the residue away.
    always_comb begin
        state_d        = state_q;
        residue_d      = residue_q;
        flushPend_d    = flushPend_q;
        overflow_d     = overflow_q;
        wrEn0          = 1'b0;
        wrEn1          = 1'b0;
        wrByte0        = 8'h00;
        wrByte1        = 8'h00;
        sampleAccepted = 1'b0;

        if (din_valid) begin
            if (low_res) begin
                state_d = ST_EVEN;
                if (freeSpace >= ONE_C) begin
                    wrEn0          = 1'b1;
                    wrByte0        = lowResByte;
                    sampleAccepted = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end else if (state_q == ST_EVEN) begin
                if (freeSpace >= ONE_C) begin
                    wrEn0          = 1'b1;
                    wrByte0        = sample[11:4];
                    residue_d      = sample[3:0];
                    state_d        = ST_ODD;
                    sampleAccepted = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end else begin
                if (freeSpace >= TWO_C) begin
                    wrEn0          = 1'b1;
                    wrByte0        = {residue_q, sample[11:8]};
                    wrEn1          = 1'b1;
                    wrByte1        = sample[7:0];
                    state_d        = ST_EVEN;
                    sampleAccepted = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end else if (low_res) begin
            state_d     = ST_EVEN;
            flushPend_d = 1'b0;
        end else if (flushPend_q) begin
            // A pending flush only acts on an idle cycle. With nothing held it
            // simply retires. With a residue it waits until there is room.
            if (state_q == ST_ODD) begin
                if (freeSpace >= ONE_C) begin
                    wrEn0       = 1'b1;
                    wrByte0     = {residue_q, 4'b0000};
                    state_d     = ST_EVEN;
                    flushPend_d = 1'b0;
                end
            end else begin
                flushPend_d = 1'b0;
            end
        end

        if (flush) begin
            flushPend_d = 1'b1;
        end
    end

    // FIFO bookkeeping and the registered head. The head register always
    // shows the byte that will be at rdPtr after this edge. So a byte written
    // at one edge reaches dout one edge later, and back-to-back pops still run
    // at one byte per clock. While the consumer stalls, dout reloads the same
    // slot, which cannot be overwritten because it is still counted as used.
    always_comb begin
        wrPtrPlus1  = wrPtr_q + PTR_W'(1);
        wrPtr_d     = wrPtr_q + PTR_W'(wrEn0) + PTR_W'(wrEn1);
        rdNext      = pop ? (rdPtr_q + PTR_W'(1)) : rdPtr_q;
        rdPtr_d     = rdNext;
        remaining   = count_q - pCOUNT_WIDTH'(pop);
        count_d     = remaining + pCOUNT_WIDTH'(wrEn0) + pCOUNT_WIDTH'(wrEn1);
        doutValid_d = (remaining != '0);
        dout_d      = dout_q;
        if (doutValid_d) begin
            dout_d = mem[rdNext];
        end
    end

    // Byte storage. It has no reset because the count and pointers decide
    // which slots are meaningful. A pair write fills two adjacent slots.
    always_ff @(posedge adc_sampleclk) begin
        if (wrEn0) begin
            mem[wrPtr_q] <= wrByte0;
        end
        if (wrEn1) begin
            mem[wrPtrPlus1] <= wrByte1;
        end
    end

    // All control state. clear behaves like reset but synchronously, and it
    // overrides any sample, flush or pop arriving in the same cycle.
    always_ff @(posedge adc_sampleclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_EVEN;
            residue_q   <= 4'h0;
            flushPend_q <= 1'b0;
            overflow_q  <= 1'b0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            dout_q      <= 8'h00;
            doutValid_q <= 1'b0;
        end else if (clear) begin
            state_q     <= ST_EVEN;
            residue_q   <= 4'h0;
            flushPend_q <= 1'b0;
            overflow_q  <= 1'b0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            dout_q      <= 8'h00;
            doutValid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            residue_q   <= residue_d;
            flushPend_q <= flushPend_d;
            overflow_q  <= overflow_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            doutValid_q <= doutValid_d;
        end
    end

    assign dout            = dout_q;
    assign dout_valid      = doutValid_q;
    assign overflow        = overflow_q;
    assign fifo_count      = count_q;
    assign residue_pending = (state_q == ST_ODD);

endmodule

// File: tb/tb_adc_byte_packer.sv
//-----------------------------------------------------------------------------
// tb_adc_byte_packer
//
// Directed bench for adc_byte_packer. Expected bytes are hand-computed from
// the packing rules. Every byte the consumer takes is captured into a queue
// and compared after each scenario.
//-----------------------------------------------------------------------------
module tb_adc_byte_packer;

    logic        adc_sampleclk;
    logic        reset_n;
    logic        clear;
    logic        low_res;
    logic [11:0] din;
    logic        din_valid;
    logic        flush;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        overflow;
    logic [4:0]  fifo_count;
    logic        residue_pending;

    int          testCount = 0;
    int          failCount = 0;
    int          seqErrors;
    logic [7:0]  got [$];

    adc_byte_packer #(
        .pFIFO_DEPTH  (16),
        .pCOUNT_WIDTH (5)
    ) dut (
        .adc_sampleclk   (adc_sampleclk),
        .reset_n         (reset_n),
        .clear           (clear),
        .low_res         (low_res),
        .din             (din),
        .din_valid       (din_valid),
        .flush           (flush),
        .dout            (dout),
        .dout_valid      (dout_valid),
        .dout_ready      (dout_ready),
        .overflow        (overflow),
        .fifo_count      (fifo_count),
        .residue_pending (residue_pending)
    );

    // 100 MHz sample clock
    initial adc_sampleclk = 1'b0;
    always #5 adc_sampleclk = ~adc_sampleclk;

    // Record every byte that the next rising edge will hand to the consumer.
    always @(negedge adc_sampleclk) begin
        if (reset_n && dout_valid && dout_ready) begin
            got.push_back(dout);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] gotAt(input int idx);
        if (idx < got.size()) begin
            return 32'(got[idx]);
        end
        return 32'hDEAD;
    endfunction

    task automatic tick();
        @(posedge adc_sampleclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    // Present one sample for exactly one clock edge.
    task automatic applyStimulus(input logic [11:0] d);
        din       = d;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b1;
        clear      = 1'b0;
        low_res    = 1'b1;
        din        = 12'h000;
        din_valid  = 1'b0;
        flush      = 1'b0;
        dout_ready = 1'b1;

        #2 reset_n = 1'b0;
        idle(2);
        checkOutput("rst_dout",       32'(dout),            32'h0);
        checkOutput("rst_dout_valid", 32'(dout_valid),      32'h0);
        checkOutput("rst_overflow",   32'(overflow),        32'h0);
        checkOutput("rst_count",      32'(fifo_count),      32'h0);
        checkOutput("rst_residue",    32'(residue_pending), 32'h0);
        @(negedge adc_sampleclk);
        reset_n = 1'b1;
        idle(2);

`ifdef ADC_BYTE_PACKER_TESTPATTERN_EN
        // Pattern counter in 8-bit mode, drained continuously
        clear = 1'b1;
        tick();
        clear = 1'b0;
        got.delete();
        low_res    = 1'b1;
        dout_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(12'h000);
        end
        idle(6);
        checkOutput("tp_size", 32'(got.size()), 32'd300);
        seqErrors = 0;
        for (int i = 1; i < got.size(); i++) begin
            if (got[i] !== 8'(got[i-1] + 8'd1)) begin
                seqErrors++;
            end
        end
        checkOutput("tp_first",    gotAt(0),       32'h00);
        checkOutput("tp_seq_errs", 32'(seqErrors), 32'd0);
        checkOutput("tp_overflow", 32'(overflow),  32'h0);
`else
        // 8-bit mode: one byte per sample, two-edge latency to dout_valid
        got.delete();
        low_res = 1'b1;
        applyStimulus(12'h120);
        checkOutput("m8_lat_edge1", 32'(dout_valid), 32'h0);
        applyStimulus(12'h130);
        checkOutput("m8_lat_edge2", 32'(dout_valid), 32'h1);
        checkOutput("m8_first",     32'(dout),       32'h12);
        applyStimulus(12'h140);
        idle(4);
        checkOutput("m8_size", 32'(got.size()), 32'd3);
        checkOutput("m8_b0",   gotAt(0),        32'h12);
        checkOutput("m8_b1",   gotAt(1),        32'h13);
        checkOutput("m8_b2",   gotAt(2),        32'h14);
        checkOutput("m8_empty", 32'(dout_valid), 32'h0);

        // 12-bit packed pair
        got.delete();
        low_res = 1'b0;
        tick();
        applyStimulus(12'hABC);
        checkOutput("m12_res_after_s0", 32'(residue_pending), 32'h1);
        applyStimulus(12'h123);
        checkOutput("m12_res_after_s1", 32'(residue_pending), 32'h0);
        idle(5);
        checkOutput("m12_size", 32'(got.size()), 32'd3);
        checkOutput("m12_b0",   gotAt(0),        32'hAB);
        checkOutput("m12_b1",   gotAt(1),        32'hC1);
        checkOutput("m12_b2",   gotAt(2),        32'h23);

        // Lone sample followed by flush pads the residue with zeros
        got.delete();
        applyStimulus(12'h5A7);
        checkOutput("fl_res_held", 32'(residue_pending), 32'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        checkOutput("fl_res_clear", 32'(residue_pending), 32'h0);
        idle(4);
        checkOutput("fl_size", 32'(got.size()), 32'd2);
        checkOutput("fl_b0",   gotAt(0),        32'h5A);
        checkOutput("fl_b1",   gotAt(1),        32'h70);

        // Fill with the consumer stalled: 11 samples fill all 16 bytes,
        // the 12th (ODD, needs 2, free 0) is dropped
        got.delete();
        dout_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(12'(k) * 12'h111);
        end
        checkOutput("ov_count10", 32'(fifo_count), 32'd15);
        checkOutput("ov_flag10",  32'(overflow),   32'h0);
        applyStimulus(12'hBBB);
        checkOutput("ov_count11", 32'(fifo_count),      32'd16);
        checkOutput("ov_res11",   32'(residue_pending), 32'h1);
        checkOutput("ov_flag11",  32'(overflow),        32'h0);
        applyStimulus(12'hCCC);
        checkOutput("ov_count12", 32'(fifo_count),      32'd16);
        checkOutput("ov_flag12",  32'(overflow),        32'h1);
        checkOutput("ov_res12",   32'(residue_pending), 32'h1);
        checkOutput("ov_head",    32'(dout),            32'h11);
        checkOutput("ov_headv",   32'(dout_valid),      32'h1);
        // Pop one byte, then an ODD sample with free=1 is still dropped
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        checkOutput("ov_count_pop", 32'(fifo_count), 32'd15);
        checkOutput("ov_head2",     32'(dout),       32'h12);
        checkOutput("ov_popped",    gotAt(0),        32'h11);
        applyStimulus(12'hDDD);
        checkOutput("ov_count_free1", 32'(fifo_count),      32'd15);
        checkOutput("ov_res_free1",   32'(residue_pending), 32'h1);
        idle(2);
        checkOutput("ov_stable", 32'(dout), 32'h12);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("clr_count",   32'(fifo_count),      32'd0);
        checkOutput("clr_flag",    32'(overflow),        32'h0);
        checkOutput("clr_res",     32'(residue_pending), 32'h0);
        checkOutput("clr_valid",   32'(dout_valid),      32'h0);
        checkOutput("clr_dout",    32'(dout),            32'h0);

        // Switching to 8-bit mode discards a held residue
        got.delete();
        dout_ready = 1'b1;
        low_res    = 1'b0;
        applyStimulus(12'hDEF);
        checkOutput("lr_res_held", 32'(residue_pending), 32'h1);
        low_res = 1'b1;
        tick();
        checkOutput("lr_res_drop", 32'(residue_pending), 32'h0);
        applyStimulus(12'h340);
        idle(4);
        checkOutput("lr_size", 32'(got.size()), 32'd2);
        checkOutput("lr_b0",   gotAt(0),        32'hDE);
        checkOutput("lr_b1",   gotAt(1),        32'h34);

        // Asynchronous reset mid-stream with 7 bytes queued
        low_res    = 1'b0;
        dout_ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(12'h100 + 12'(k));
        end
        checkOutput("ar_count_pre", 32'(fifo_count),      32'd7);
        checkOutput("ar_res_pre",   32'(residue_pending), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("ar_valid", 32'(dout_valid),      32'h0);
        checkOutput("ar_dout",  32'(dout),            32'h0);
        checkOutput("ar_count", 32'(fifo_count),      32'd0);
        checkOutput("ar_res",   32'(residue_pending), 32'h0);
        @(negedge adc_sampleclk);
        reset_n = 1'b1;
        tick();
        got.delete();
        dout_ready = 1'b1;
        applyStimulus(12'h456);
        applyStimulus(12'h789);
        idle(5);
        checkOutput("ar_size", 32'(got.size()),      32'd3);
        checkOutput("ar_b0",   gotAt(0),             32'h45);
        checkOutput("ar_b1",   gotAt(1),             32'h67);
        checkOutput("ar_b2",   gotAt(2),             32'h89);
        checkOutput("ar_res2", 32'(residue_pending), 32'h0);
        checkOutput("ar_flag", 32'(overflow),        32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
